// File: rtl/alu_seq_pkg.sv
// Shared constants, op-codes, flag positions and FSM encoding for the ALU sequencer.
package alu_seq_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned NUM_REGS = 4;
    localparam int unsigned ADDR_W   = 2;
    localparam int unsigned OP_W     = 3;
    localparam int unsigned FLAG_W   = 4;

    // Flag bit positions inside the stored {C,A,E,Z} vector
    localparam int unsigned FLAG_C = 3;
    localparam int unsigned FLAG_A = 2;
    localparam int unsigned FLAG_E = 1;
    localparam int unsigned FLAG_Z = 0;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SHR = 3'b001,
        OP_SHL = 3'b010,
        OP_NOT = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_CMP = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD_TMP = 2'd1,
        ST_EXEC     = 2'd2,
        ST_WB       = 2'd3
    } seq_state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// Request handshake and completion bus between a host and the sequencer.
interface alu_sequencer_if;
    import alu_seq_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [OP_W-1:0]   req_op;
    logic [ADDR_W-1:0] req_ra;
    logic [ADDR_W-1:0] req_rb;
    logic [ADDR_W-1:0] req_rd;
    logic              req_cin_sel;
    logic              done;

    modport master (
        output req_valid, req_op, req_ra, req_rb, req_rd, req_cin_sel,
        input  req_ready, done
    );

    modport slave (
        input  req_valid, req_op, req_ra, req_rb, req_rd, req_cin_sel,
        output req_ready, done
    );

endinterface

// File: rtl/alu_sequencer_reg_file4.sv
// 4x8 register file: one write port, two operand read ports and a host read port.
module reg_file4
    import alu_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a_c,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b_c,
    input  logic [ADDR_W-1:0] raddr_h,
    output logic [DATA_W-1:0] rdata_h_c
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // Storage with async clear and a single write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata_a_c = regs_q[raddr_a];
    assign rdata_b_c = regs_q[raddr_b];
    assign rdata_h_c = regs_q[raddr_h];

endmodule

// File: rtl/alu_sequencer.sv
// Four-stage sequencer driving an external ALU from a small register file.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREGS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    alu_sequencer_if.slave           bus,
    input  logic                     host_wr_en,
    input  logic [$clog2(NREGS)-1:0] host_wr_addr,
    input  logic [WIDTH-1:0]         host_wr_data,
    input  logic [$clog2(NREGS)-1:0] host_rd_addr,
    output logic [WIDTH-1:0]         host_rd_data,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic                     alu_carry_in,
    output logic [OP_W-1:0]          alu_op,
    input  logic [WIDTH-1:0]         alu_out,
    input  logic                     alu_A,
    input  logic                     alu_E,
    input  logic                     alu_Z,
    input  logic                     alu_C,
    output logic [FLAG_W-1:0]        flags
);

    seq_state_e        state_q, state_d;
    logic              accept_c;
    alu_op_e           op_q;
    logic [ADDR_W-1:0] ra_q, rb_q, rd_q;
    logic              cin_sel_q;
    logic [WIDTH-1:0]  acc_q;
    logic              rf_we_c;
    logic [ADDR_W-1:0] rf_waddr_c;
    logic [WIDTH-1:0]  rf_wdata_c;
    logic [WIDTH-1:0]  rf_a_c, rf_b_c;

    assign accept_c = bus.req_valid & bus.req_ready;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: a fixed three-stage walk once a request is taken
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (accept_c) state_d = ST_LOAD_TMP;
            ST_LOAD_TMP: state_d = ST_EXEC;
            ST_EXEC:     state_d = ST_WB;
            ST_WB:       state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.req_ready <= 1'b1;
            bus.done      <= 1'b0;
        end else begin
            bus.req_ready <= (state_d == ST_IDLE);
            bus.done      <= (state_d == ST_WB);
        end
    end

    // Capture the request fields on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_ADD;
            ra_q      <= '0;
            rb_q      <= '0;
            rd_q      <= '0;
            cin_sel_q <= 1'b0;
        end else if (accept_c) begin
            op_q      <= alu_op_e'(bus.req_op);
            ra_q      <= bus.req_ra;
            rb_q      <= bus.req_rb;
            rd_q      <= bus.req_rd;
            cin_sel_q <= bus.req_cin_sel;
        end
    end

    // ALU operand registers: loaded leaving LOAD_TMP so they are live only during EXEC;
    // alu_b doubles as TMP since it holds R[rb] for exactly that cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= '0;
            alu_carry_in <= 1'b0;
        end else if (state_q == ST_LOAD_TMP) begin
            alu_a        <= rf_a_c;
            alu_b        <= rf_b_c;
            alu_op       <= op_q;
            alu_carry_in <= cin_sel_q & flags[FLAG_C];
        end else begin
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= '0;
            alu_carry_in <= 1'b0;
        end
    end

    // Latch ALU result and flags at the end of EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            flags <= '0;
        end else if (state_q == ST_EXEC) begin
            acc_q         <= alu_out;
            flags[FLAG_C] <= alu_C;
            flags[FLAG_A] <= alu_A;
            flags[FLAG_E] <= alu_E;
            flags[FLAG_Z] <= alu_Z;
        end
    end

    // Register-file write port: host in IDLE, writeback in WB (CMP writes flags only)
    always_comb begin
        rf_we_c    = 1'b0;
        rf_waddr_c = host_wr_addr;
        rf_wdata_c = host_wr_data;
        if (state_q == ST_IDLE) begin
            rf_we_c = host_wr_en;
        end else if ((state_q == ST_WB) && (op_q != OP_CMP)) begin
            rf_we_c    = 1'b1;
            rf_waddr_c = rd_q;
            rf_wdata_c = acc_q;
        end
    end

    reg_file4 u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (rf_we_c),
        .waddr     (rf_waddr_c),
        .wdata     (rf_wdata_c),
        .raddr_a   (ra_q),
        .rdata_a_c (rf_a_c),
        .raddr_b   (rb_q),
        .rdata_b_c (rf_b_c),
        .raddr_h   (host_rd_addr),
        .rdata_h_c (host_rd_data)
    );

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer with a reference 8-bit ALU attached.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       host_wr_en;
    logic [1:0] host_wr_addr;
    logic [7:0] host_wr_data;
    logic [1:0] host_rd_addr;
    logic [7:0] host_rd_data;
    logic [7:0] alu_a, alu_b, alu_out;
    logic       alu_carry_in;
    logic [2:0] alu_op;
    logic       alu_A, alu_E, alu_Z, alu_C;
    logic [3:0] flags;
    logic [11:0] alu_res;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_r [4];
    logic [3:0] m_flags;
    logic [7:0] rd_vals [4];

    alu_sequencer_if bus ();

    alu_sequencer #(.WIDTH(8), .NREGS(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .host_wr_en   (host_wr_en),
        .host_wr_addr (host_wr_addr),
        .host_wr_data (host_wr_data),
        .host_rd_addr (host_rd_addr),
        .host_rd_data (host_rd_data),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_carry_in (alu_carry_in),
        .alu_op       (alu_op),
        .alu_out      (alu_out),
        .alu_A        (alu_A),
        .alu_E        (alu_E),
        .alu_Z        (alu_Z),
        .alu_C        (alu_C),
        .flags        (flags)
    );

    always #5 clk = ~clk;

    // Reference ALU: returns {C, A, E, Z, result[7:0]}
    function automatic logic [11:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic cin);
        logic [8:0] s;
        logic [7:0] r;
        logic c, ag, eq;
        s = '0; r = '0; c = 1'b0; ag = 1'b0; eq = 1'b0;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b} + 9'(cin); r = s[7:0]; c = s[8]; end
            3'd1: begin r = a >> 1; c = a[0]; end
            3'd2: begin r = a << 1; c = a[7]; end
            3'd3: r = ~a;
            3'd4: r = a & b;
            3'd5: r = a | b;
            3'd6: r = a ^ b;
            default: begin r = a - b; c = (a < b); ag = (a > b); eq = (a == b); end
        endcase
        return {c, ag, eq, (r == 8'd0), r};
    endfunction

    always_comb alu_res = alu_fn(alu_op, alu_a, alu_b, alu_carry_in);
    assign alu_out = alu_res[7:0];
    assign alu_Z   = alu_res[8];
    assign alu_E   = alu_res[9];
    assign alu_A   = alu_res[10];
    assign alu_C   = alu_res[11];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one operation to the architectural model
    task automatic model_op(input logic [2:0] op, input logic [1:0] ra, input logic [1:0] rb,
                            input logic [1:0] rd, input logic cin);
        logic [11:0] res;
        res = alu_fn(op, m_r[ra], m_r[rb], cin & m_flags[3]);
        m_flags = res[11:8];
        if (op != 3'b111) m_r[rd] = res[7:0];
    endtask

    // Called at posedge+1; reads all registers over the host port, ends at the negedge
    task automatic check_state(input string tag);
        for (int i = 0; i < 4; i++) begin
            host_rd_addr = 2'(i);
            #1;
            rd_vals[i] = host_rd_data;
            check_eq($sformatf("%s_r%0d", tag, i), host_rd_data, m_r[i]);
        end
        check_eq({tag, "_flags"}, flags, m_flags);
        check_eq({tag, "_alu_idle"}, {alu_a, alu_b, alu_op, alu_carry_in}, 0);
        check_eq({tag, "_done_idle"}, bus.done, 0);
    endtask

    task automatic host_write(input logic [1:0] a, input logic [7:0] d);
        host_wr_en = 1'b1; host_wr_addr = a; host_wr_data = d;
        @(posedge clk); #1;
        host_wr_en = 1'b0;
        m_r[a] = d;
    endtask

    // hw_mode: 0 none, 1 host write in accept cycle, 2 host write held through LOAD_TMP/EXEC
    task automatic run_op(input logic [2:0] op, input logic [1:0] ra, input logic [1:0] rb,
                          input logic [1:0] rd, input logic cin, input int hw_mode,
                          input logic [1:0] hw_addr, input logic [7:0] hw_data);
        logic [7:0] ea, eb;
        logic       ecin;
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_ra = ra; bus.req_rb = rb;
        bus.req_rd = rd; bus.req_cin_sel = cin;
        if (hw_mode == 1) begin
            host_wr_en = 1'b1; host_wr_addr = hw_addr; host_wr_data = hw_data;
        end
        @(negedge clk);
        check_eq("op_ready_idle", bus.req_ready, 1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        host_wr_en = 1'b0;
        if (hw_mode == 1) m_r[hw_addr] = hw_data;
        ea = m_r[ra]; eb = m_r[rb]; ecin = cin & m_flags[3];
        if (hw_mode == 2) begin
            host_wr_en = 1'b1; host_wr_addr = hw_addr; host_wr_data = hw_data;
        end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check_eq($sformatf("op_ready_busy_c%0d", c), bus.req_ready, 0);
            check_eq($sformatf("op_done_c%0d", c), bus.done, (c == 3));
            if (c == 2) begin
                check_eq("exec_alu_a", alu_a, ea);
                check_eq("exec_alu_b", alu_b, eb);
                check_eq("exec_alu_op", alu_op, op);
                check_eq("exec_alu_cin", alu_carry_in, ecin);
            end else begin
                check_eq($sformatf("alu_zero_c%0d", c), {alu_a, alu_b, alu_op, alu_carry_in}, 0);
            end
            if (c < 3) begin
                @(posedge clk); #1;
                if (c == 2) host_wr_en = 1'b0;
            end
        end
        model_op(op, ra, rb, rd, cin);
        @(posedge clk); #1;
        check_state("op");
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        host_wr_en = 1'b0; host_wr_addr = '0; host_wr_data = '0; host_rd_addr = '0;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_ra = '0; bus.req_rb = '0;
        bus.req_rd = '0; bus.req_cin_sel = 1'b0;
        for (int i = 0; i < 4; i++) m_r[i] = '0;
        m_flags = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_state("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("reset_ready", bus.req_ready, 1);
        @(posedge clk); #1;

        // ADD 0x0F + 0x01
        host_write(2'd0, 8'h0F);
        host_write(2'd1, 8'h01);
        run_op(3'd0, 2'd0, 2'd1, 2'd2, 1'b0, 0, 2'd0, 8'h00);
        check_eq("add_r2", rd_vals[2], 8'h10);
        check_eq("add_flags", flags, 4'b0000);

        // Wrap to zero, then carry chained in
        host_write(2'd0, 8'hFF);
        run_op(3'd0, 2'd0, 2'd1, 2'd3, 1'b0, 0, 2'd0, 8'h00);
        check_eq("wrap_r3", rd_vals[3], 8'h00);
        check_eq("wrap_flags", flags, 4'b1001);
        run_op(3'd0, 2'd0, 2'd1, 2'd3, 1'b1, 0, 2'd0, 8'h00);
        check_eq("carry_r3", rd_vals[3], 8'h01);
        check_eq("carry_flags", flags, 4'b1000);

        // CMP equal and above; destination untouched
        host_write(2'd0, 8'h55);
        host_write(2'd1, 8'h55);
        run_op(3'd7, 2'd0, 2'd1, 2'd2, 1'b0, 0, 2'd0, 8'h00);
        check_eq("cmp_eq_flags", flags, 4'b0011);
        check_eq("cmp_eq_r2", rd_vals[2], 8'h10);
        host_write(2'd0, 8'h80);
        host_write(2'd1, 8'h01);
        run_op(3'd7, 2'd0, 2'd1, 2'd2, 1'b0, 0, 2'd0, 8'h00);
        check_eq("cmp_gt_flags", flags, 4'b0100);
        check_eq("cmp_gt_r2", rd_vals[2], 8'h10);

        // Host write while busy is dropped; in the accept cycle it is used
        run_op(3'd0, 2'd0, 2'd1, 2'd3, 1'b0, 2, 2'd1, 8'hAA);
        check_eq("busy_wr_r3", rd_vals[3], 8'h81);
        check_eq("busy_wr_r1", rd_vals[1], 8'h01);
        run_op(3'd0, 2'd0, 2'd1, 2'd3, 1'b0, 1, 2'd1, 8'hAA);
        check_eq("acc_wr_r3", rd_vals[3], 8'h2A);
        check_eq("acc_wr_r1", rd_vals[1], 8'hAA);

        // Back-to-back XOR with valid held high and fields changing every cycle
        bus.req_op = 3'd6;
        for (int cyc = 0; cyc < 24; cyc++) begin
            bus.req_valid = 1'b1;
            bus.req_ra = 2'($urandom_range(0, 3));
            bus.req_rb = 2'($urandom_range(0, 3));
            bus.req_rd = 2'($urandom_range(0, 3));
            bus.req_cin_sel = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_eq($sformatf("b2b_ready_%0d", cyc), bus.req_ready, ((cyc % 4) == 0));
            check_eq($sformatf("b2b_done_%0d", cyc), bus.done, ((cyc % 4) == 3));
            if ((cyc % 4) == 0)
                model_op(3'd6, bus.req_ra, bus.req_rb, bus.req_rd, bus.req_cin_sel);
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        check_state("b2b");
        @(posedge clk); #1;

        // Randomized operations with occasional host writes
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 2) == 0)
                host_write(2'($urandom_range(0, 3)), 8'($urandom));
            run_op(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                   2'($urandom_range(0, 3)), 8'($urandom));
        end

        // Reset in the middle of EXEC
        host_write(2'd0, 8'h3C);
        host_write(2'd1, 8'hC3);
        host_write(2'd2, 8'h5A);
        bus.req_valid = 1'b1; bus.req_op = 3'd0; bus.req_ra = 2'd0; bus.req_rb = 2'd1;
        bus.req_rd = 2'd2; bus.req_cin_sel = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_mid_exec_alu_a", alu_a, 8'h3C);
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) m_r[i] = '0;
        m_flags = '0;
        check_state("rst_mid");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_eq($sformatf("rst_no_done_%0d", c), bus.done, 0);
            check_eq($sformatf("rst_ready_%0d", c), bus.req_ready, 1);
            @(posedge clk); #1;
        end
        check_state("post_rst");
        @(posedge clk); #1;

        // Operation after abort
        host_write(2'd0, 8'h12);
        host_write(2'd1, 8'h34);
        run_op(3'd5, 2'd0, 2'd1, 2'd2, 1'b0, 0, 2'd0, 8'h00);
        check_eq("post_rst_or_r2", rd_vals[2], 8'h36);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: WIDTH, 8, datapath width; only 8 is supported.
REQ-002 Parameter: NREGS, 4, general registers R0..R3; only 4 is supported.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  operation request present.
REQ-006 req_ready  output  1  sequencer can accept a request this cycle.
REQ-007 req_op  input  3  ALU op: 000 ADD, 001 SHR, 010 SHL, 011 NOT, 100 AND, 101 OR, 110 XOR, 111 CMP.
REQ-008 req_ra / req_rb / req_rd  input  2 each  source-A, source-B and destination register index.
REQ-009 req_cin_sel  input  1  1 = carry_in from stored C flag, 0 = carry_in 0.
REQ-010 host_wr_en / host_wr_addr / host_wr_data  input  1 / 2 / 8  host register write port.
REQ-011 host_rd_addr / host_rd_data  input 2 / output 8  combinational host register read.
REQ-012 alu_a / alu_b / alu_carry_in / alu_op  output  8 / 8 / 1 / 3  operands and control to the ALU.
REQ-013 alu_out / alu_A / alu_E / alu_Z / alu_C  input  8 / 1 / 1 / 1 / 1  ALU result and flags.
REQ-014 flags  output  4  stored flags {C,A,E,Z}, bit 3 = C.
REQ-015 done  output  1  one-cycle pulse when an operation completes.

Function
REQ-016 FSM states: IDLE, LOAD_TMP, EXEC, WB; transitions IDLE->LOAD_TMP on accept, then unconditionally LOAD_TMP->EXEC->WB->IDLE.
REQ-017 req_ready = 1 only in IDLE; accept = req_valid & req_ready; op, ra, rb, rd, cin_sel captured on accept.
REQ-018 LOAD_TMP: TMP <= R[rb].
REQ-019 EXEC: alu_a = R[ra], alu_b = TMP, alu_op = captured op, alu_carry_in = cin_sel & flags[3]; at end of cycle ACC <= alu_out and flags <= {alu_C, alu_A, alu_E, alu_Z}.
REQ-020 Outside EXEC, alu_a, alu_b, alu_carry_in, alu_op drive 0.
REQ-021 WB: R[rd] <= ACC unless op = 111 (CMP), which updates flags only; done = 1 for this single cycle.
REQ-022 Latency: accept edge to done cycle = 3 cycles; next accept earliest in cycle after done (4-cycle throughput).
REQ-023 ra = rb = rd permitted; sources read as before WB of the same operation.
REQ-024 host_wr_en honoured only in IDLE (including the accept cycle; later stages see the new value); ignored in other states.
REQ-025 Stored C sampled during EXEC of the current operation, i.e. carry from the previous completed operation.
REQ-026 8-bit arithmetic wraps; overflow reported only through alu_C as stored in flags.

Reset
REQ-027 rst_n low asynchronously forces IDLE, R0..R3, TMP, ACC, flags to 0, done = 0, req_ready = 1 after release.
REQ-028 Reset mid-operation aborts it: no writeback, no done pulse, no flag update.

Structure
REQ-029 Package alu_seq_pkg holds op-code constants, FSM state encoding, flag bit indices (C=3, A=2, E=1, Z=0).
REQ-030 Register file is a separate sub-module reg_file4: 4x8, one write port, two combinational read ports plus host read port, async active-low reset.
REQ-031 ALU is external; sequencer contains no ALU logic.

Verification (bench connects a reference 8-bit ALU model)
REQ-032 Reset mid-EXEC of ADD -> all registers 0, flags 0, no done, req_ready = 1 after release.
REQ-033 R0=0x0F, R1=0x01, ADD ra=0 rb=1 rd=2 cin_sel=0 -> done 3 cycles after accept, R2=0x10, flags=0000.
REQ-034 R0=0xFF, R1=0x01, ADD rd=3 -> R3=0x00, flags C=1, Z=1; then ADD R0+R1 with cin_sel=1 -> result 0x01, C=1.
REQ-035 R0=0x55, R1=0x55, CMP -> E=1, A=0, R[rd] unchanged; R0=0x80, R1=0x01 CMP -> A=1, E=0.
REQ-036 req_valid held high for back-to-back XOR ops -> req_ready low during LOAD_TMP/EXEC/WB, accepts exactly every 4 cycles, one done per op.
REQ-037 host_wr_en to R1=0xAA during EXEC -> write ignored; same write in accept cycle -> operation uses 0xAA.
